// File: rtl/register_file_wb.sv
// Register file with a one-deep registered write-back stage feeding the ALU operands.
// Results park in a pending stage, commit to the array one edge later, and reads bypass from it.
module register_file_wb #(
    parameter int DATA_WIDTH = 8,
    parameter int REG_COUNT  = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] readreg1,
    input  logic [ADDR_WIDTH-1:0] readreg2,
    output logic [DATA_WIDTH-1:0] readdata1,
    output logic [DATA_WIDTH-1:0] readdata2,
    input  logic                  wb_valid,
    input  logic [ADDR_WIDTH-1:0] wb_reg,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  wb_ready,
    input  logic                  hold,
    output logic [7:0]            commit_count
);

    logic [DATA_WIDTH-1:0] array_q [REG_COUNT];
    logic [DATA_WIDTH-1:0] array_d [REG_COUNT];
    logic                  pend_valid_q, pend_valid_d;
    logic [ADDR_WIDTH-1:0] pend_reg_q, pend_reg_d;
    logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
    logic [7:0]            commit_count_q, commit_count_d;

    logic accept;
    logic commit;

    always_comb begin
        wb_ready = !pend_valid_q || !hold;
        accept   = wb_valid && wb_ready;
        commit   = pend_valid_q && !hold;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        array_d        = array_q;
        pend_valid_d   = pend_valid_q;
        pend_reg_d     = pend_reg_q;
        pend_data_d    = pend_data_q;
        commit_count_d = commit_count_q;

        if (commit) begin
            // Register 0 is hardwired to zero, so its commit only counts.
            if (pend_reg_q != '0) begin
                array_d[pend_reg_q] = pend_data_q;
            end
            commit_count_d = commit_count_q + 8'd1;
            pend_valid_d   = 1'b0;
        end

        // An accept on the commit edge refills the stage, keeping pend_valid high.
        if (accept) begin
            pend_valid_d = 1'b1;
            pend_reg_d   = wb_reg;
            pend_data_d  = wb_data;
        end
    end

    // NOTE: the array is reset along with the control state because reads must return 0 right after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                array_q[i] <= '0;
            end
            pend_valid_q   <= 1'b0;
            pend_reg_q     <= '0;
            pend_data_q    <= '0;
            commit_count_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
            array_q        <= array_d;
            pend_valid_q   <= pend_valid_d;
            pend_reg_q     <= pend_reg_d;
            pend_data_q    <= pend_data_d;
            commit_count_q <= commit_count_d;
        end
    end

    // Operand reads: zero register, then pending-stage bypass, then the array.
    always_comb begin
        readdata1 = '0;
        if (readreg1 != '0) begin
            if (pend_valid_q && (pend_reg_q == readreg1)) begin
                readdata1 = pend_data_q;
            end else begin
                readdata1 = array_q[readreg1];
            end
        end
    end

    always_comb begin
        readdata2 = '0;
        if (readreg2 != '0) begin
            if (pend_valid_q && (pend_reg_q == readreg2)) begin
                readdata2 = pend_data_q;
            end else begin
                readdata2 = array_q[readreg2];
            end
        end
    end

    assign commit_count = commit_count_q;

endmodule

// File: tb/tb_register_file_wb.sv
// Directed bench for register_file_wb: a small architectural model plus a queue of
// accepted write-backs whose bypass readback is compared right after acceptance.
module tb_register_file_wb;

    logic       clk;
    logic       reset_n;
    logic [1:0] readreg1, readreg2;
    logic [7:0] readdata1, readdata2;
    logic       wb_valid;
    logic [1:0] wb_reg;
    logic [7:0] wb_data;
    logic       wb_ready;
    logic       hold;
    logic [7:0] commit_count;

    register_file_wb dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .readreg1     (readreg1),
        .readreg2     (readreg2),
        .readdata1    (readdata1),
        .readdata2    (readdata2),
        .wb_valid     (wb_valid),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .wb_ready     (wb_ready),
        .hold         (hold),
        .commit_count (commit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] r;
        logic [7:0] d;
    } wb_item_t;

    wb_item_t exp_q[$];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model of the architectural state.
    logic [7:0] m_arr [4];
    logic       m_pv;
    logic [1:0] m_pr;
    logic [7:0] m_pd;
    logic [7:0] m_cnt;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_read(input logic [1:0] r);
        if (r == 2'd0) return 8'h00;
        if (m_pv && m_pr == r) return m_pd;
        return m_arr[r];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_arr[i] = 8'h00;
        m_pv  = 1'b0;
        m_pr  = 2'd0;
        m_pd  = 8'h00;
        m_cnt = 8'h00;
        exp_q.delete();
    endtask

    // One rising edge: update the model from the pre-edge inputs, then check handshake,
    // counter and, when a write-back was accepted, its bypass readback.
    task automatic tick();
        logic     acc, com;
        wb_item_t it;
        acc = wb_valid && (!m_pv || !hold);
        com = m_pv && !hold;
        if (acc) exp_q.push_back('{r: wb_reg, d: wb_data});
        @(posedge clk);
        if (com) begin
            if (m_pr != 2'd0) m_arr[m_pr] = m_pd;
            m_cnt = m_cnt + 8'd1;
        end
        if (acc) begin
            m_pv = 1'b1;
            m_pr = wb_reg;
            m_pd = wb_data;
        end else if (com) begin
            m_pv = 1'b0;
        end
        #1;
        check("wb_ready", {7'd0, wb_ready}, {7'd0, (!m_pv || !hold)});
        check("commit_count", commit_count, m_cnt);
        if (acc) begin
            it = exp_q.pop_front();
            readreg1 = it.r;
            #1;
            check("bypass_readback", readdata1, (it.r == 2'd0) ? 8'h00 : it.d);
        end
    endtask

    task automatic check_reads(input string tag);
        for (int i = 0; i < 4; i++) begin
            readreg1 = 2'(i);
            readreg2 = 2'(3 - i);
            #1;
            check({tag, "_p1"}, readdata1, m_read(2'(i)));
            check({tag, "_p2"}, readdata2, m_read(2'(3 - i)));
        end
    endtask

    initial begin
        reset_n  = 1'b1;
        readreg1 = 2'd0;
        readreg2 = 2'd0;
        wb_valid = 1'b0;
        wb_reg   = 2'd0;
        wb_data  = 8'h00;
        hold     = 1'b0;
        model_reset();

        // Reset pulse mid-cycle: outputs settle without any clock edge.
        #2 reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            readreg1 = 2'(i);
            readreg2 = 2'(i);
            #0.5;
            check("reset_rd1", readdata1, 8'h00);
            check("reset_rd2", readdata2, 8'h00);
        end
        check("reset_ready", {7'd0, wb_ready}, 8'h01);
        check("reset_count", commit_count, 8'h00);
        @(negedge clk) reset_n = 1'b1;

        // Write and bypass.
        wb_valid = 1'b1; wb_reg = 2'd2; wb_data = 8'hA5;
        tick();
        wb_valid = 1'b0; readreg1 = 2'd2;
        #1 check("bypass_N", readdata1, 8'hA5);
        tick();
        readreg1 = 2'd2;
        #1 check("bypass_N1", readdata1, 8'hA5);
        check("count_after_first", commit_count, 8'h01);

        // Back-to-back writes to the same register.
        wb_valid = 1'b1; wb_reg = 2'd3; wb_data = 8'h11;
        tick();
        readreg2 = 2'd3;
        #1 check("b2b_first", readdata2, 8'h11);
        wb_data = 8'h22;
        tick();
        readreg2 = 2'd3;
        #1 check("b2b_second", readdata2, 8'h22);
        wb_valid = 1'b0;
        tick();
        readreg2 = 2'd3;
        #1 check("b2b_array", readdata2, 8'h22);
        check("b2b_count", commit_count, 8'h03);

        // Register 0 write is discarded but still counted.
        wb_valid = 1'b1; wb_reg = 2'd0; wb_data = 8'hFF; readreg1 = 2'd0;
        #1 check("r0_before", readdata1, 8'h00);
        tick();
        readreg1 = 2'd0;
        #1 check("r0_pending", readdata1, 8'h00);
        wb_valid = 1'b0;
        tick();
        readreg1 = 2'd0;
        #1 check("r0_committed", readdata1, 8'h00);
        check("r0_count", commit_count, 8'h04);

        // Hold backpressure with a waiting source.
        wb_valid = 1'b1; wb_reg = 2'd1; wb_data = 8'h3C;
        tick();
        hold = 1'b1; wb_data = 8'h77;
        for (int i = 0; i < 3; i++) begin
            readreg1 = 2'd1;
            #1;
            check("hold_ready", {7'd0, wb_ready}, 8'h00);
            check("hold_read", readdata1, 8'h3C);
            check("hold_count", commit_count, 8'h04);
            tick();
        end
        hold = 1'b0;
        #1 check("release_ready", {7'd0, wb_ready}, 8'h01);
        tick();
        readreg1 = 2'd1;
        #1 check("release_read", readdata1, 8'h77);
        check("release_count", commit_count, 8'h05);
        wb_valid = 1'b0;
        tick();
        check_reads("after_hold");

        // Hold with an empty stage still accepts one entry.
        hold = 1'b1; wb_valid = 1'b1; wb_reg = 2'd3; wb_data = 8'h99;
        #1 check("hold_empty_ready", {7'd0, wb_ready}, 8'h01);
        tick();
        wb_valid = 1'b0;
        #1 check("hold_full_ready", {7'd0, wb_ready}, 8'h00);
        hold = 1'b0;
        tick();
        check_reads("hold_empty");

        // Reset while an entry is pending: it is lost, everything reads zero.
        wb_valid = 1'b1; wb_reg = 2'd2; wb_data = 8'h5A;
        tick();
        wb_valid = 1'b0;
        @(negedge clk) reset_n = 1'b0;
        model_reset();
        check_reads("midreset");
        check("midreset_count", commit_count, 8'h00);
        check("midreset_ready", {7'd0, wb_ready}, 8'h01);
        @(negedge clk) reset_n = 1'b1;
        tick();
        check_reads("post_reset");

        // 256 commits wrap the counter back to zero.
        wb_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            wb_reg  = 2'(i);
            wb_data = 8'(i);
            tick();
        end
        wb_valid = 1'b0;
        check("wrap_255", commit_count, 8'hFF);
        tick();
        check("wrap_0", commit_count, 8'h00);
        check_reads("wrap_final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
